cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Write-back (common data bus) arbiter between the functional units and the two ROB write-back broadcast channels. Each producer (ALU, load/store buffer, branch unit, …) pushes `(rob_idx, value)` results into a private skid FIFO. Each cycle the block grants up to two FIFO heads, round-robin, onto broadcast slots 1 and 2. Those slots drive the ROB and the `rob_wb_valid1/2`, `rob_wb_idx1/2` and `rob_wb_val1/2` wake-up inputs of the reservation station and load/store buffer.

## Interface
- `N_SRC`, default 3: number of producers; 2..8.
- `FIFO_DEPTH`, default 2: entries per producer FIFO; power of two, ≥2.
- `IDX_W`, default `` `ROB_SIZE_BIT ``: ROB index width.
- `clk_in` input 1: system clock; only clock.
- `rst_in` input 1: asynchronous, active-low reset.
- `rdy_in` input 1: pause; all state frozen when low.
- `rob_clear` input 1: synchronous flush (mispredict).
- `src_valid` input `N_SRC`: producer s offers a result.
- `src_idx` input `N_SRC*IDX_W`: packed ROB indices; slice s belongs to producer s.
- `src_val` input `N_SRC*32`: packed result values.
- `src_ready` output `N_SRC`: producer s may push this cycle.
- `wb_valid1` output 1: slot 1 broadcast valid.
- `wb_idx1` output `IDX_W`: slot 1 ROB index.
- `wb_val1` output 32: slot 1 value.
- `wb_valid2` output 1: slot 2 broadcast valid.
- `wb_idx2` output `IDX_W`: slot 2 ROB index.
- `wb_val2` output 32: slot 2 value.

## Operation
- **Per-source FIFO.** Circular buffer with head/tail pointers (`$clog2(FIFO_DEPTH)` bits, wrapping) and a count of `$clog2(FIFO_DEPTH)+1` bits.
- **Push.** A push occurs when `src_valid[s] && src_ready[s]`.
  - `src_ready[s] = rdy_in && rst_in && !rob_clear && count[s] < FIFO_DEPTH`.
  - The condition is based on the registered count only. A full FIFO is not ready even if it is popped in the same cycle, so there is no grant-to-ready combinational path.
- **Candidates.** Source s is a candidate when `count[s] != 0`.
- **Round-robin grant.**
  - Slot 1 takes the first candidate at or after `rr_ptr`, searching modulo `N_SRC`.
  - Slot 2 takes the next candidate after slot 1's source, in the same search order, excluding slot 1's source.
  - At most one pop per source per cycle.
  - If there is exactly one candidate, only slot 1 is valid.
- **Broadcast.** The granted FIFO heads drive `wb_idx`/`wb_val`. When a slot is not valid, its idx and val are 0.
- **Pop.** Every granted head is popped at the clock edge.
- **`rr_ptr` update.** `rr_ptr <= (last granted source + 1) mod N_SRC`, where "last" is the slot 2 source if slot 2 is valid, otherwise the slot 1 source. `rr_ptr` is unchanged when nothing is granted.
- **Simultaneous push and pop** on the same FIFO: count unchanged, both pointers advance.
- **Mutual exclusion.** `wb_idx1 != wb_idx2` is the producers' responsibility; the ROB never hands out one index twice. The arbiter does not check it.
- **`rdy_in` low.**
  - `wb_valid1/2` are forced to 0 and `src_ready` is 0.
  - Counts, pointers and `rr_ptr` hold.
- **`rob_clear` high (while `rdy_in` high).**
  - All counts and pointers go to 0 and `rr_ptr` goes to 0.
  - Pushes in that cycle are dropped (`src_ready` is already 0).
  - `wb_valid1/2` are forced to 0 in that cycle.
- **Reset (`rst_in` low, any time, including mid-burst).**
  - Counts, pointers and `rr_ptr` go to 0.
  - `wb_valid1/2`, `wb_idx*` and `wb_val*` read 0; `src_ready` is 0.
  - FIFO data storage need not be reset.

## Timing
- **Latency.** A result pushed at edge t can broadcast in the cycle after t at the earliest. There is no same-cycle bypass.
- **Outputs.** `wb_*` are combinational from registered FIFO state plus masking by `rdy_in` and `rob_clear`.
- **Throughput.** 2 results per cycle aggregate, 1 per source per cycle.
- **Starvation bound.** A non-empty source is granted within `ceil(N_SRC/2)` cycles of becoming the oldest waiting candidate.
- **Reset release.** `src_ready` rises in the first cycle `rst_in` is high (given `rdy_in`); `wb_valid*` stays 0 until the first push has landed.

## Structure
- **Shared constants.** `ROB_SIZE_BIT` and the default depth `WB_FIFO_DEPTH` belong in `config.v`.
- **Sub-module `wb_fifo`.** One instance per source.
  - Generics: depth and width.
  - Contents: storage, head/tail/count, push/pop, flush, a `full` flag and a head view.
  - Async active-low reset.
- **Top level.** The grant logic (two-level rotate-and-priority-encode) and the `rr_ptr` register.

## Test plan
- **Reset and single push.** Reset, then push `src0` (idx 5, val `0x1234`) in cycle 1. Required: cycle 2 `wb_valid1=1`, `idx1=5`, `val1=0x1234`, `wb_valid2=0`; cycle 3 both valid 0.
- **Three sources at once.** All three push in the same cycle with idx 1, 2, 3 and `rr_ptr=0`.
  - Next cycle: slot 1 carries idx 1, slot 2 carries idx 2, and `rr_ptr` becomes 2.
  - Following cycle: slot 1 carries idx 3, then `rr_ptr` becomes 0.
- **Backpressure.** `src1` pushes every cycle while only it and `src0` are active and `src0` is also full. Required: `src1` count saturates at 2, `src_ready[1]=0` when full, no entry is lost, and the broadcast order per source is FIFO.
- **Flush mid-burst.** With 2 entries queued in each FIFO, raise `rob_clear` for one cycle while pushing. Required: `wb_valid*=0` that cycle, and all counts are 0 and no broadcast occurs in the next cycle.
- **Pause.** Hold `rdy_in` low for 3 cycles with queued entries. Required: no broadcasts and `src_ready=0`; after release, the queued entries broadcast in the same order as without the pause.
- **Asynchronous reset mid-operation.** Assert `rst_in` low between clock edges while FIFOs are non-empty. Required: outputs go to 0 immediately, without waiting for a clock edge, and after release all FIFOs are empty.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared widths, default sizes and round-robin helper for the write-back arbiter
package cdb_arbiter_pkg;
  localparam int ROB_SIZE_BIT = 5;
  localparam int WB_FIFO_DEPTH = 2;
  localparam int DATA_W = 32;
  function automatic int rr_add(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction
endpackage

// File: rtl/cdb_arbiter_wb_fifo.sv
// cdb_arbiter_wb_fifo: per-producer skid FIFO with flush, full flag and head view
module cdb_arbiter_wb_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 37
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         rdy,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] hd, tl;
  logic [AW:0] cnt;
  always_ff @(posedge clk_in)
    if (rdy && !clear && push) mem[tl] <= din;
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) begin
      hd <= '0;
      tl <= '0;
      cnt <= '0;
    end else if (rdy) begin
      if (clear) begin
        hd <= '0;
        tl <= '0;
        cnt <= '0;
      end else begin
        hd <= hd + AW'(pop);
        tl <= tl + AW'(push);
        cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      end
    end
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign head = mem[hd];
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: grants up to two producer FIFO heads per cycle, round-robin, onto the two ROB write-back slots
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N_SRC = 3,
  parameter int FIFO_DEPTH = WB_FIFO_DEPTH,
  parameter int IDX_W = ROB_SIZE_BIT
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    rob_clear,
  input  logic [N_SRC-1:0]        src_valid,
  input  logic [N_SRC*IDX_W-1:0]  src_idx,
  input  logic [N_SRC*DATA_W-1:0] src_val,
  output logic [N_SRC-1:0]        src_ready,
  output logic                    wb_valid1,
  output logic [IDX_W-1:0]        wb_idx1,
  output logic [DATA_W-1:0]       wb_val1,
  output logic                    wb_valid2,
  output logic [IDX_W-1:0]        wb_idx2,
  output logic [DATA_W-1:0]       wb_val2
);
  localparam int PW = $clog2(N_SRC);
  localparam int EW = IDX_W + DATA_W;
  logic en, v1, v2;
  logic [N_SRC-1:0] full, empty, push, pop;
  logic [EW-1:0] head [N_SRC];
  logic [PW-1:0] rr_ptr, s1, s2;
  int c;
  assign en = rdy_in && rst_in && !rob_clear;
  // readiness uses registered fullness only, keeping grants out of the ready path
  assign src_ready = {N_SRC{en}} & ~full;
  assign push = src_valid & src_ready;
  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    assign pop[i] = (wb_valid1 && s1 == PW'(i)) || (wb_valid2 && s2 == PW'(i));
    cdb_arbiter_wb_fifo #(.DEPTH(FIFO_DEPTH), .W(EW)) u_fifo (
      .clk_in(clk_in),
      .rst_in(rst_in),
      .rdy(rdy_in),
      .clear(rob_clear),
      .push(push[i]),
      .pop(pop[i]),
      .din({src_idx[i*IDX_W +: IDX_W], src_val[i*DATA_W +: DATA_W]}),
      .full(full[i]),
      .empty(empty[i]),
      .head(head[i])
    );
  end
  always_comb begin
    v1 = 1'b0;
    v2 = 1'b0;
    s1 = '0;
    s2 = '0;
    c = 0;
    for (int k = 0; k < N_SRC; k++) begin
      c = rr_add(int'(rr_ptr), k, N_SRC);
      if (!empty[c] && !v1) begin
        v1 = 1'b1;
        s1 = PW'(c);
      end else if (!empty[c] && !v2) begin
        v2 = 1'b1;
        s2 = PW'(c);
      end
    end
  end
  assign wb_valid1 = en && v1;
  assign wb_valid2 = en && v2;
  assign wb_idx1 = wb_valid1 ? head[s1][EW-1:DATA_W] : '0;
  assign wb_val1 = wb_valid1 ? head[s1][DATA_W-1:0] : '0;
  assign wb_idx2 = wb_valid2 ? head[s2][EW-1:DATA_W] : '0;
  assign wb_val2 = wb_valid2 ? head[s2][DATA_W-1:0] : '0;
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) rr_ptr <= '0;
    else if (rdy_in) begin
      if (rob_clear) rr_ptr <= '0;
      else if (v1) rr_ptr <= PW'(rr_add(int'(v2 ? s2 : s1), 1, N_SRC));
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed checks of grant order, backpressure, flush, pause and async reset
module tb_cdb_arbiter;
  localparam int N = 3;
  localparam int IW = 5;
  logic clk_in = 1'b0;
  logic rst_in, rdy_in, rob_clear;
  logic [N-1:0] src_valid, src_ready;
  logic [N*IW-1:0] src_idx;
  logic [N*32-1:0] src_val;
  logic wb_valid1, wb_valid2;
  logic [IW-1:0] wb_idx1, wb_idx2;
  logic [31:0] wb_val1, wb_val2;
  int tests = 0;
  int fails = 0;

  cdb_arbiter #(.N_SRC(N), .FIFO_DEPTH(2), .IDX_W(IW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
    .src_valid(src_valid), .src_idx(src_idx), .src_val(src_val), .src_ready(src_ready),
    .wb_valid1(wb_valid1), .wb_idx1(wb_idx1), .wb_val1(wb_val1),
    .wb_valid2(wb_valid2), .wb_idx2(wb_idx2), .wb_val2(wb_val2)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_src(input int s, input int idx, input logic [31:0] val);
    src_valid[s] = 1'b1;
    src_idx[s*IW +: IW] = IW'(idx);
    src_val[s*32 +: 32] = val;
  endtask

  task automatic do_reset;
    rst_in = 1'b0;
    src_valid = '0;
    rob_clear = 1'b0;
    rdy_in = 1'b1;
    #2;
    rst_in = 1'b1;
    tick;
  endtask

  task automatic test_reset;
    rst_in = 1'b0;
    rdy_in = 1'b1;
    rob_clear = 1'b0;
    src_valid = '0;
    set_src(0, 3, 32'h55);
    set_src(1, 4, 32'h66);
    #7;
    tests++;
    if ({wb_valid1, wb_valid2, wb_idx1, wb_val1, wb_idx2, wb_val2, src_ready} !== '0) begin
      fails++;
      $display("FAIL reset_outputs v1=%b v2=%b idx1=%0d idx2=%0d rdy=%b required all 0", wb_valid1, wb_valid2, wb_idx1, wb_idx2, src_ready);
    end
    src_valid = '0;
    rst_in = 1'b1;
    #1;
    tests++;
    if ({src_ready, wb_valid1, wb_valid2} !== {3'b111, 2'b00}) begin
      fails++;
      $display("FAIL reset_release rdy=%b v1=%b v2=%b required rdy=111 v1=0 v2=0", src_ready, wb_valid1, wb_valid2);
    end
    tick;
  endtask

  task automatic test_single_push;
    do_reset;
    set_src(0, 5, 32'h1234);
    tick;
    src_valid = '0;
    #1;
    tests++;
    if ({wb_valid1, wb_idx1, wb_val1, wb_valid2} !== {1'b1, 5'd5, 32'h1234, 1'b0}) begin
      fails++;
      $display("FAIL single_push v1=%b idx1=%0d val1=%h v2=%b required 1/5/1234/0", wb_valid1, wb_idx1, wb_val1, wb_valid2);
    end
    tick;
    tests++;
    if ({wb_valid1, wb_valid2} !== 2'b00) begin
      fails++;
      $display("FAIL single_drain v1=%b v2=%b required 0/0", wb_valid1, wb_valid2);
    end
  endtask

  task automatic test_three_sources;
    do_reset;
    set_src(0, 1, 32'hA001);
    set_src(1, 2, 32'hA002);
    set_src(2, 3, 32'hA003);
    tick;
    src_valid = '0;
    #1;
    tests++;
    if ({wb_valid1, wb_idx1, wb_val1, wb_valid2, wb_idx2, wb_val2} !== {1'b1, 5'd1, 32'hA001, 1'b1, 5'd2, 32'hA002}) begin
      fails++;
      $display("FAIL three_first idx1=%0d idx2=%0d v1=%b v2=%b required 1/2 both valid", wb_idx1, wb_idx2, wb_valid1, wb_valid2);
    end
    tick;
    set_src(0, 6, 32'hA006);
    set_src(2, 7, 32'hA007);
    #1;
    tests++;
    if ({wb_valid1, wb_idx1, wb_val1, wb_valid2, wb_idx2} !== {1'b1, 5'd3, 32'hA003, 1'b0, 5'd0}) begin
      fails++;
      $display("FAIL three_second v1=%b idx1=%0d v2=%b idx2=%0d required 1/3/0/0", wb_valid1, wb_idx1, wb_valid2, wb_idx2);
    end
    tick;
    src_valid = '0;
    #1;
    tests++;
    if ({wb_valid1, wb_idx1, wb_valid2, wb_idx2} !== {1'b1, 5'd6, 1'b1, 5'd7}) begin
      fails++;
      $display("FAIL rr_wrap_to_0 idx1=%0d idx2=%0d required 6/7", wb_idx1, wb_idx2);
    end
    tick;
    tests++;
    if ({wb_valid1, wb_valid2} !== 2'b00) begin
      fails++;
      $display("FAIL three_drain v1=%b v2=%b required 0/0", wb_valid1, wb_valid2);
    end
  endtask

  task automatic test_rr_rotation;
    do_reset;
    set_src(0, 1, 32'hA001);
    set_src(1, 2, 32'hA002);
    set_src(2, 3, 32'hA003);
    tick;
    src_valid = '0;
    set_src(0, 4, 32'hA004);
    tick;
    src_valid = '0;
    #1;
    tests++;
    if ({wb_valid1, wb_idx1, wb_valid2, wb_idx2, wb_val2} !== {1'b1, 5'd3, 1'b1, 5'd4, 32'hA004}) begin
      fails++;
      $display("FAIL rr_ptr_2 idx1=%0d idx2=%0d required 3/4", wb_idx1, wb_idx2);
    end
  endtask

  task automatic test_backpressure;
    int e_v1 [8] = '{0, 1, 1, 1, 1, 1, 1, 0};
    int e_i1 [8] = '{0, 0, 16, 9, 2, 18, 11, 0};
    int e_v2 [8] = '{0, 1, 1, 1, 1, 1, 1, 0};
    int e_i2 [8] = '{0, 8, 1, 17, 10, 3, 19, 0};
    logic [2:0] e_rdy [8] = '{3'b111, 3'b111, 3'b011, 3'b101, 3'b110, 3'b011, 3'b111, 3'b111};
    int seq [N] = '{0, 0, 0};
    logic [N-1:0] hs;
    logic [31:0] ev1, ev2;
    do_reset;
    for (int c = 0; c < 8; c++) begin
      src_valid = '0;
      if (c < 5) for (int s = 0; s < N; s++) set_src(s, s*8 + seq[s], 32'hA000 + 32'(s*8 + seq[s]));
      #1;
      ev1 = e_v1[c] != 0 ? 32'hA000 + 32'(e_i1[c]) : 32'h0;
      ev2 = e_v2[c] != 0 ? 32'hA000 + 32'(e_i2[c]) : 32'h0;
      tests++;
      if ({wb_valid1, wb_idx1, wb_val1, wb_valid2, wb_idx2, wb_val2, src_ready} !==
          {1'(e_v1[c]), 5'(e_i1[c]), ev1, 1'(e_v2[c]), 5'(e_i2[c]), ev2, e_rdy[c]}) begin
        fails++;
        $display("FAIL backpressure c%0d got v1=%b i1=%0d v2=%b i2=%0d rdy=%b required v1=%0d i1=%0d v2=%0d i2=%0d rdy=%b",
                 c, wb_valid1, wb_idx1, wb_valid2, wb_idx2, src_ready, e_v1[c], e_i1[c], e_v2[c], e_i2[c], e_rdy[c]);
      end
      hs = src_valid & src_ready;
      tick;
      for (int s = 0; s < N; s++) if (hs[s]) seq[s]++;
    end
    src_valid = '0;
  endtask

  task automatic test_flush;
    do_reset;
    for (int s = 0; s < N; s++) set_src(s, s*8, 32'hA000 + 32'(s*8));
    tick;
    for (int s = 0; s < N; s++) set_src(s, s*8 + 1, 32'hA000 + 32'(s*8 + 1));
    tick;
    rob_clear = 1'b1;
    for (int s = 0; s < N; s++) set_src(s, s*8 + 2, 32'hA000 + 32'(s*8 + 2));
    #1;
    tests++;
    if ({wb_valid1, wb_valid2, src_ready} !== 5'b00_000) begin
      fails++;
      $display("FAIL flush_cycle v1=%b v2=%b rdy=%b required 0/0/000", wb_valid1, wb_valid2, src_ready);
    end
    tick;
    rob_clear = 1'b0;
    src_valid = '0;
    #1;
    tests++;
    if ({wb_valid1, wb_valid2, src_ready} !== 5'b00_111) begin
      fails++;
      $display("FAIL flush_after v1=%b v2=%b rdy=%b required 0/0/111", wb_valid1, wb_valid2, src_ready);
    end
    set_src(0, 20, 32'hA014);
    set_src(2, 21, 32'hA015);
    tick;
    src_valid = '0;
    #1;
    tests++;
    if ({wb_valid1, wb_idx1, wb_valid2, wb_idx2} !== {1'b1, 5'd20, 1'b1, 5'd21}) begin
      fails++;
      $display("FAIL flush_rr_reset idx1=%0d idx2=%0d required 20/21", wb_idx1, wb_idx2);
    end
  endtask

  task automatic test_pause;
    do_reset;
    set_src(0, 1, 32'hA001);
    set_src(1, 2, 32'hA002);
    set_src(2, 3, 32'hA003);
    tick;
    rdy_in = 1'b0;
    set_src(0, 9, 32'hA009);
    set_src(1, 10, 32'hA00A);
    set_src(2, 11, 32'hA00B);
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if ({wb_valid1, wb_valid2, src_ready} !== 5'b00_000) begin
        fails++;
        $display("FAIL pause_%0d v1=%b v2=%b rdy=%b required 0/0/000", i, wb_valid1, wb_valid2, src_ready);
      end
      tick;
    end
    rdy_in = 1'b1;
    src_valid = '0;
    #1;
    tests++;
    if ({wb_valid1, wb_idx1, wb_valid2, wb_idx2} !== {1'b1, 5'd1, 1'b1, 5'd2}) begin
      fails++;
      $display("FAIL pause_resume1 idx1=%0d idx2=%0d required 1/2", wb_idx1, wb_idx2);
    end
    tick;
    tests++;
    if ({wb_valid1, wb_idx1, wb_valid2} !== {1'b1, 5'd3, 1'b0}) begin
      fails++;
      $display("FAIL pause_resume2 v1=%b idx1=%0d v2=%b required 1/3/0", wb_valid1, wb_idx1, wb_valid2);
    end
    tick;
    tests++;
    if ({wb_valid1, wb_valid2} !== 2'b00) begin
      fails++;
      $display("FAIL pause_drain v1=%b v2=%b required 0/0", wb_valid1, wb_valid2);
    end
  endtask

  task automatic test_async_reset;
    do_reset;
    set_src(0, 1, 32'hA001);
    set_src(1, 2, 32'hA002);
    set_src(2, 3, 32'hA003);
    tick;
    src_valid = '0;
    #1;
    tests++;
    if ({wb_valid1, wb_valid2} !== 2'b11) begin
      fails++;
      $display("FAIL areset_pre v1=%b v2=%b required 1/1", wb_valid1, wb_valid2);
    end
    #2;
    rst_in = 1'b0;
    #1;
    tests++;
    if ({wb_valid1, wb_valid2, wb_idx1, wb_val1, wb_idx2, wb_val2, src_ready} !== '0) begin
      fails++;
      $display("FAIL areset_immediate v1=%b v2=%b idx1=%0d idx2=%0d rdy=%b required all 0", wb_valid1, wb_valid2, wb_idx1, wb_idx2, src_ready);
    end
    #3;
    rst_in = 1'b1;
    tick;
    tests++;
    if ({wb_valid1, wb_valid2, src_ready} !== 5'b00_111) begin
      fails++;
      $display("FAIL areset_empty v1=%b v2=%b rdy=%b required 0/0/111", wb_valid1, wb_valid2, src_ready);
    end
  endtask

  initial begin
    src_idx = '0;
    src_val = '0;
    test_reset;
    test_single_push;
    test_three_sources;
    test_rr_rotation;
    test_backpressure;
    test_flush;
    test_pause;
    test_async_reset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
